// File: rtl/mul_pkg.sv
// Shared types and helpers for the shift-add multiply-accumulate block.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int MUL_DEFAULT_WIDTH = 32;

  // Bits needed to hold values 0..value-1; sizes the step counter.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-add step: conditionally accumulate, then shift the operands.
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next
);

  // Add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_next    = acc;
    mcand_next  = {mcand[2*WIDTH-2:0], 1'b0};
    mplier_next = {1'b0, mplier[WIDTH-1:1]};
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end else begin
      acc_next = acc;
    end
  end

endmodule

// File: rtl/mul_add_unsigned.sv
// Iterative unsigned multiply-accumulate: product = a*b + c in WIDTH+1 enabled cycles.
module mul_add_unsigned
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clken,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = clog2(WIDTH);

  mul_state_t         state_r;
  mul_state_t         state_s;
  logic               load_s;
  logic               ready_r;
  logic               done_r;
  logic [2*WIDTH-1:0] product_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      count_r;
  logic [2*WIDTH-1:0] acc_step_s;
  logic [2*WIDTH-1:0] mcand_step_s;
  logic [WIDTH-1:0]   mplier_step_s;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc         (acc_r),
    .mcand       (mcand_r),
    .mplier      (mplier_r),
    .acc_next    (acc_step_s),
    .mcand_next  (mcand_step_s),
    .mplier_next (mplier_step_s)
  );

  // Next-state decode; a new operation may start from IDLE or straight out of DONE.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = BUSY;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (count_r == {CW{1'b0}}) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (start) begin
          state_s = BUSY;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; everything freezes while clken is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      product_r <= {(2*WIDTH){1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      mcand_r   <= {(2*WIDTH){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
    end else if (clken) begin
      state_r <= state_s;
      ready_r <= (state_s == IDLE) || (state_s == DONE);
      done_r  <= (state_s == DONE);
      if (load_s) begin
        acc_r    <= {{WIDTH{1'b0}}, c};
        mcand_r  <= {{WIDTH{1'b0}}, a};
        mplier_r <= b;
        count_r  <= CW'(WIDTH - 1);
      end else if (state_r == BUSY) begin
        acc_r    <= acc_step_s;
        mcand_r  <= mcand_step_s;
        mplier_r <= mplier_step_s;
        if (count_r != {CW{1'b0}}) begin
          count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
          count_r <= count_r;
        end
      end else begin
        acc_r    <= acc_r;
        mcand_r  <= mcand_r;
        mplier_r <= mplier_r;
        count_r  <= count_r;
      end
      // The final step's sum is captured directly so no extra cycle is needed.
      if ((state_r == BUSY) && (state_s == DONE)) begin
        product_r <= acc_step_s;
      end else begin
        product_r <= product_r;
      end
    end else begin
      state_r <= state_r;
    end
  end

  assign ready   = ready_r;
  assign done    = done_r;
  assign product = product_r;

endmodule
